// File: rtl/rf_op_sequencer.sv
// Sequences one register-to-register command through read, execute, write-back and report.
// Latency: 4 cycles handshake-to-done; backpressure: cmd_ready is high only in IDLE.
module rf_op_sequencer #(
    parameter int W = 16,
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic [N-1:0] cmd_rd,
    input  logic [N-1:0] cmd_rs1,
    input  logic [N-1:0] cmd_rs2,
    input  logic [W-1:0] cmd_imm,
    output logic         rf_we,
    output logic [N-1:0] rf_addr_rd,
    output logic [N-1:0] rf_addr_rs1,
    output logic [N-1:0] rf_addr_rs2,
    output logic [W-1:0] rf_data_in,
    input  logic [W-1:0] rf_rs1,
    input  logic [W-1:0] rf_rs2,
    output logic         done,
    output logic [W-1:0] result,
    output logic         flag_z,
    output logic         flag_c
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_EXEC  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDI = 3'b101;
    localparam logic [2:0] OP_MOV = 3'b110;
    localparam logic [2:0] OP_CMP = 3'b111;

    state_t       state_q;
    logic [2:0]   op_q;
    logic [N-1:0] rd_q, rs1_q, rs2_q;
    logic [W-1:0] imm_q, a_q, b_q;
    logic [W-1:0] alu_q;
    logic         z_q, c_q;
    logic         ready_q, rf_we_q, done_q;
    logic [W-1:0] result_q;
    logic         flag_z_q, flag_c_q;

    logic [W-1:0] alu_d;
    logic         c_d;
    logic [W:0]   sum;
    logic [W-1:0] diff;

    assign sum  = {1'b0, a_q} + {1'b0, b_q};
    assign diff = a_q - b_q;

    always_comb begin
        alu_d = '0;
        c_d   = 1'b0;
        case (op_q)
            OP_ADD:  begin alu_d = sum[W-1:0]; c_d = sum[W]; end
            OP_SUB,
            OP_CMP:  begin alu_d = diff; c_d = (a_q < b_q); end
            OP_AND:  alu_d = a_q & b_q;
            OP_OR:   alu_d = a_q | b_q;
            OP_XOR:  alu_d = a_q ^ b_q;
            OP_LDI:  alu_d = imm_q;
            OP_MOV:  alu_d = a_q;
            default: alu_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            imm_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            alu_q    <= '0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            ready_q  <= 1'b0;
            rf_we_q  <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid && ready_q) begin
                        op_q    <= cmd_op;
                        rd_q    <= cmd_rd;
                        rs1_q   <= cmd_rs1;
                        rs2_q   <= cmd_rs2;
                        imm_q   <= cmd_imm;
                        ready_q <= 1'b0;
                        state_q <= S_READ;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                S_READ: begin
                    a_q     <= rf_rs1;
                    b_q     <= rf_rs2;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    alu_q   <= alu_d;
                    z_q     <= (alu_d == '0);
                    c_q     <= c_d;
                    // r0 is read-only and CMP only reports flags
                    rf_we_q <= (rd_q != '0) && (op_q != OP_CMP);
                    state_q <= S_WRITE;
                end
                S_WRITE: begin
                    rf_we_q  <= 1'b0;
                    done_q   <= 1'b1;
                    result_q <= alu_q;
                    flag_z_q <= z_q;
                    flag_c_q <= c_q;
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Gating with reset keeps a reset raised mid-cycle from letting a write or done escape.
    assign rf_we       = rf_we_q & reset;
    assign done        = done_q & reset;
    assign cmd_ready   = ready_q & reset;
    assign rf_addr_rd  = rd_q;
    assign rf_addr_rs1 = rs1_q;
    assign rf_addr_rs2 = rs2_q;
    assign rf_data_in  = alu_q;
    assign result      = result_q;
    assign flag_z      = flag_z_q;
    assign flag_c      = flag_c_q;

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Directed bench for rf_op_sequencer with a behavioural register bank.
module tb_rf_op_sequencer;
    localparam int W = 16;
    localparam int N = 5;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [2:0]   cmd_op = '0;
    logic [N-1:0] cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
    logic [W-1:0] cmd_imm = '0;
    logic         rf_we;
    logic [N-1:0] rf_addr_rd, rf_addr_rs1, rf_addr_rs2;
    logic [W-1:0] rf_data_in, rf_rs1, rf_rs2;
    logic         done;
    logic [W-1:0] result;
    logic         flag_z, flag_c;

    logic [W-1:0] bank [2**N] = '{default: '0};

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] r_res, r_we_dat;
    logic         r_z, r_c;
    logic [N-1:0] r_we_addr;
    int           r_we_cnt, r_we_cyc, r_done_cyc;

    always #5 clk = ~clk;

    assign rf_rs1 = bank[rf_addr_rs1];
    assign rf_rs2 = bank[rf_addr_rs2];
    always @(posedge clk) if (rf_we) bank[rf_addr_rd] <= rf_data_in;

    rf_op_sequencer #(.W(W), .N(N)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
        .rf_we(rf_we), .rf_addr_rd(rf_addr_rd), .rf_addr_rs1(rf_addr_rs1), .rf_addr_rs2(rf_addr_rs2),
        .rf_data_in(rf_data_in), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
        .done(done), .result(result), .flag_z(flag_z), .flag_c(flag_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issues one command, then scrambles cmd_* to show later changes are ignored.
    task automatic run_cmd(input logic [2:0] op, input logic [N-1:0] rd, input logic [N-1:0] rs1,
                           input logic [N-1:0] rs2, input logic [W-1:0] imm);
        int n;
        @(negedge clk);
        cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
        r_we_cnt = 0; r_we_cyc = 0; r_done_cyc = 0; r_we_addr = '0; r_we_dat = '0;
        if (!cmd_ready) begin
            check("ready_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op = ~op; cmd_rd = ~rd; cmd_rs1 = ~rs1; cmd_rs2 = ~rs2; cmd_imm = ~imm;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (rf_we) begin
                r_we_cnt++; r_we_cyc = cyc; r_we_addr = rf_addr_rd; r_we_dat = rf_data_in;
            end
            if (done) begin
                r_done_cyc = cyc; r_res = result; r_z = flag_z; r_c = flag_c;
                break;
            end
        end
    endtask

    task automatic expect_cmd(input string tag, input logic [W-1:0] res, input logic z, input logic c,
                              input logic we, input logic [N-1:0] rd);
        check({tag, "_done_cyc"}, 32'(r_done_cyc), 32'd4);
        check({tag, "_result"}, 32'(r_res), 32'(res));
        check({tag, "_z"}, 32'(r_z), 32'(z));
        check({tag, "_c"}, 32'(r_c), 32'(c));
        check({tag, "_we_cnt"}, 32'(r_we_cnt), we ? 32'd1 : 32'd0);
        if (we) begin
            check({tag, "_we_cyc"}, 32'(r_we_cyc), 32'd3);
            check({tag, "_we_addr"}, 32'(r_we_addr), 32'(rd));
            check({tag, "_we_dat"}, 32'(r_we_dat), 32'(res));
        end
    endtask

    initial begin
        int rdy_cnt, done_cnt, hs;
        logic [W-1:0] last_res;

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(cmd_ready), 32'd0);
        check("rst_we", 32'(rf_we), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_out", {13'd0, flag_z, flag_c, 1'b0, result}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("rel_ready", 32'(cmd_ready), 32'd1);

        run_cmd(3'b101, 5'd3, 5'd0, 5'd0, 16'h1234); expect_cmd("ldi3", 16'h1234, 0, 0, 1, 5'd3);
        run_cmd(3'b101, 5'd4, 5'd0, 5'd0, 16'h0FFF); expect_cmd("ldi4", 16'h0FFF, 0, 0, 1, 5'd4);
        run_cmd(3'b000, 5'd5, 5'd3, 5'd4, 16'h0);    expect_cmd("add5", 16'h2233, 0, 0, 1, 5'd5);
        run_cmd(3'b101, 5'd6, 5'd0, 5'd0, 16'hFFFF); expect_cmd("ldi6", 16'hFFFF, 0, 0, 1, 5'd6);
        run_cmd(3'b101, 5'd7, 5'd0, 5'd0, 16'h0001); expect_cmd("ldi7", 16'h0001, 0, 0, 1, 5'd7);
        run_cmd(3'b000, 5'd8, 5'd6, 5'd7, 16'h0);    expect_cmd("add8", 16'h0000, 1, 1, 1, 5'd8);
        check("r8_bank", 32'(bank[8]), 32'd0);
        run_cmd(3'b001, 5'd9, 5'd7, 5'd6, 16'h0);    expect_cmd("sub9", 16'h0002, 0, 1, 1, 5'd9);
        run_cmd(3'b111, 5'd12, 5'd3, 5'd3, 16'h0);   expect_cmd("cmp", 16'h0000, 1, 0, 0, 5'd0);
        run_cmd(3'b010, 5'd16, 5'd3, 5'd4, 16'h0);   expect_cmd("and", 16'h0234, 0, 0, 1, 5'd16);
        run_cmd(3'b011, 5'd17, 5'd3, 5'd4, 16'h0);   expect_cmd("or", 16'h1FFF, 0, 0, 1, 5'd17);
        run_cmd(3'b100, 5'd18, 5'd3, 5'd4, 16'h0);   expect_cmd("xor", 16'h1DCB, 0, 0, 1, 5'd18);
        run_cmd(3'b101, 5'd0, 5'd0, 5'd0, 16'hBEEF); expect_cmd("ldi0", 16'hBEEF, 0, 0, 0, 5'd0);
        run_cmd(3'b110, 5'd1, 5'd0, 5'd0, 16'h0);    expect_cmd("mov1", 16'h0000, 1, 0, 1, 5'd1);

        // Back-to-back with cmd_valid held high: LDI r13, then MOV r14 <- r13.
        @(negedge clk);
        cmd_op = 3'b101; cmd_rd = 5'd13; cmd_rs1 = 5'd0; cmd_rs2 = 5'd0; cmd_imm = 16'h5A5A;
        cmd_valid = 1'b1;
        rdy_cnt = 0; done_cnt = 0; hs = 0; last_res = '0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (cyc != 0) @(negedge clk);
            if (cmd_ready) begin rdy_cnt++; hs++; end
            if (done) begin done_cnt++; last_res = result; end
            @(posedge clk); #1;
            if (hs == 1) begin cmd_op = 3'b110; cmd_rd = 5'd14; cmd_rs1 = 5'd13; end
        end
        cmd_valid = 1'b0;
        check("b2b_ready_cnt", 32'(rdy_cnt), 32'd2);
        check("b2b_done_cnt", 32'(done_cnt), 32'd2);
        check("b2b_mov_res", 32'(last_res), 32'h5A5A);
        check("b2b_r14", 32'(bank[14]), 32'h5A5A);

        // Reset during the WRITE cycle of ADD r10.
        @(negedge clk);
        cmd_op = 3'b000; cmd_rd = 5'd10; cmd_rs1 = 5'd3; cmd_rs2 = 5'd4; cmd_valid = 1'b1;
        check("abort_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_we", 32'(rf_we), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        check("abort_out", {13'd0, flag_z, flag_c, done, result}, 32'd0);
        check("abort_ready_low", 32'(cmd_ready), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("abort_rel_ready", 32'(cmd_ready), 32'd1);
        check("abort_r10", 32'(bank[10]), 32'd0);
        run_cmd(3'b110, 5'd15, 5'd10, 5'd0, 16'h0); expect_cmd("mov15", 16'h0000, 1, 0, 1, 5'd15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/rf_op_sequencer.md
# rf_op_sequencer

Multi-cycle command sequencer that drives the team's register bank (2**N entries × W bits, two combinational read ports, one synchronous write port). It accepts one register-to-register command at a time over a valid/ready handshake and reads the operands. It then computes an ALU result, writes the result back to the bank, and reports the result and flags to the requester. It sits between the command source (test FSM or UART decoder) and the register bank, and is the bank's only write master.

## Interface
- W, 16, data width; must match the bank.
- N, 5, address width; the bank has 2**N entries.
- clk  in  1  single system clock; all logic is rising-edge.
- reset  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  3  opcode (see Operation).
- cmd_rd  in  N  destination register.
- cmd_rs1  in  N  source register 1.
- cmd_rs2  in  N  source register 2.
- cmd_imm  in  W  immediate value; used only by LDI.
- rf_we  out  1  write enable to the bank.
- rf_addr_rd  out  N  write address to the bank.
- rf_addr_rs1  out  N  read address, port 1.
- rf_addr_rs2  out  N  read address, port 2.
- rf_data_in  out  W  write data to the bank.
- rf_rs1  in  W  bank read data, port 1 (combinational).
- rf_rs2  in  W  bank read data, port 2 (combinational).
- done  out  1  one-cycle pulse when a command completes.
- result  out  W  result of the last completed command; held until the next done.
- flag_z  out  1  result == 0; held with result.
- flag_c  out  1  carry (ADD) or borrow (SUB/CMP); 0 for all other ops; held with result.

## Operation
- Opcode assignments:
  - 000 ADD: rs1+rs2
  - 001 SUB: rs1−rs2
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 LDI: result = cmd_imm
  - 110 MOV: result = rs1
  - 111 CMP: rs1−rs2, flags only, never writes.
- Arithmetic is unsigned, modulo 2**W.
  - ADD: flag_c is bit W of the (W+1)-bit sum.
  - SUB/CMP: flag_c = 1 iff rs1 < rs2 unsigned.
- Register 0 is write-protected: if rd == 0 (or op is CMP), the WRITE state keeps rf_we = 0. The result and flags are still reported.
- FSM states: IDLE → READ → EXEC → WRITE → DONE → IDLE. There are no other transitions.
  - IDLE: cmd_ready = 1. On cmd_valid && cmd_ready, latch op/rd/rs1/rs2/imm into internal registers and go to READ. With cmd_valid = 0, stay in IDLE.
  - READ: drive rf_addr_rs1/rs2 from the latched addresses, capture rf_rs1/rf_rs2 into operand registers, then go to EXEC.
  - EXEC: compute the result and flags into registers, then go to WRITE.
  - WRITE: rf_addr_rd = latched rd, rf_data_in = result, rf_we = 1 (subject to the rd/CMP rule above), then go to DONE.
  - DONE: done = 1; update result, flag_z and flag_c; then go to IDLE.
- cmd_ready is 0 in every state except IDLE. Any cmd_* change outside IDLE is ignored.
- rf_we is 1 only in WRITE. rf_addr_*/rf_data_in are don't-care when not used but must be stable (driven from registers).

## Timing
- Handshake occurs at edge 0. READ occupies cycle 1, EXEC cycle 2, WRITE cycle 3 (rf_we high), DONE cycle 4 (done high). cmd_ready is high again in cycle 5.
- Command-to-done latency is 4 cycles. Maximum throughput is 1 command per 5 cycles.
- A command issued immediately after done reads the value written by the previous command, because the bank write lands at the end of cycle 3.
- Reset (reset = 0 sampled on an edge):
  - state is forced to IDLE.
  - rf_we, done, result, flag_z, flag_c and all latched fields are set to 0.
  - cmd_ready is forced to 0 while reset is low, and is 1 on the first cycle after reset is released.
- Reset mid-operation aborts the command. No rf_we pulse and no done pulse are produced for that command, even if reset is asserted during WRITE.

## Test plan
- Reset, then LDI rd=3 imm=0x1234, then LDI rd=4 imm=0x0FFF → rf_we pulses at cycle 3 with addr 3/4; done at cycle 4; result 0x1234 then 0x0FFF; flag_z=0; flag_c=0.
- ADD rd=5 rs1=3 rs2=4 → result 0x2233, flag_c=0. Then LDI r6=0xFFFF, LDI r7=0x0001, ADD rd=8 rs1=6 rs2=7 → result 0x0000, flag_z=1, flag_c=1; r8 reads back 0.
- SUB rd=9 rs1=7 rs2=6 → result 0x0002, flag_c=1. CMP rs1=3 rs2=3 → flag_z=1, flag_c=0, and no rf_we pulse.
- LDI rd=0 imm=0xBEEF → done with result 0xBEEF, rf_we stays 0; a subsequent MOV rd=1 rs1=0 → result 0x0000.
- Hold cmd_valid=1 continuously with back-to-back commands → cmd_ready high exactly 1 cycle in 5; the second command sees the first command's write.
- Assert reset in the WRITE cycle of ADD rd=10 → no rf_we, no done, outputs 0; after release cmd_ready=1 and r10 reads 0.
